// File: rtl/tdm_demux.sv
// TDM link receiver: routes each valid sample to its channel register, tracks frame lock, flags framing errors.
// Latency 1 cycle from accepted sample to dout/dout_valid; no backpressure, a sample is taken on every din_valid.
module tdm_demux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    localparam int SW      = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din_valid,
    input  logic [WIDTH-1:0]          din,
    input  logic                      sync,
    input  logic                      err_clr,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic [CHANNELS-1:0]       dout_valid,
    output logic                      frame_done,
    output logic                      locked,
    output logic [SW-1:0]             slot,
    output logic                      sync_err
);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

    logic [0:0] state;

    assign locked = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            dout       <= '0;
            dout_valid <= '0;
            frame_done <= 1'b0;
            slot       <= '0;
            sync_err   <= 1'b0;
        end else begin
            dout_valid <= '0;
            frame_done <= 1'b0;
            // Clear first so that an error raised below in the same cycle wins.
            if (err_clr) begin
                sync_err <= 1'b0;
            end
            if (din_valid) begin
                if (state == HUNT) begin
                    if (sync) begin
                        dout[0 +: WIDTH] <= din;
                        dout_valid[0]    <= 1'b1;
                        slot             <= SW'(1);
                        state            <= LOCKED;
                    end
                end else if (sync) begin
                    // Early sync truncates the current frame but keeps lock.
                    if (slot != '0) begin
                        sync_err <= 1'b1;
                    end
                    dout[0 +: WIDTH] <= din;
                    dout_valid[0]    <= 1'b1;
                    slot             <= SW'(1);
                end else if (slot == '0) begin
                    sync_err <= 1'b1;
                    slot     <= '0;
                    state    <= HUNT;
                end else begin
                    dout[int'(slot)*WIDTH +: WIDTH] <= din;
                    dout_valid[slot]                <= 1'b1;
                    slot                            <= slot + SW'(1);
                    if (slot == LAST_SLOT) begin
                        frame_done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized and directed stimulus with a queue-based scoreboard against a slot/channel-array reference model.
module tb_tdm_demux;

    localparam int C  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             din_valid = 1'b0;
    logic [W-1:0]     din = '0;
    logic             sync = 1'b0;
    logic             err_clr = 1'b0;
    logic [C*W-1:0]   dout;
    logic [C-1:0]     dout_valid;
    logic             frame_done;
    logic             locked;
    logic [SW-1:0]    slot;
    logic             sync_err;

    tdm_demux #(.CHANNELS(C), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .sync       (sync),
        .err_clr    (err_clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .slot       (slot),
        .sync_err   (sync_err)
    );

    typedef struct {
        logic [C*W-1:0] dout;
        logic [C-1:0]   dv;
        logic           fd;
        logic           lk;
        logic [SW-1:0]  sl;
        logic           er;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    // Reference model state
    bit           m_locked;
    int           m_slot;
    logic [W-1:0] m_ch[C];
    bit           m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
    endtask

    task automatic drive(input bit r, input bit v, input bit s, input bit clr, input logic [W-1:0] d);
        exp_t e;
        @(negedge clk);
        rst = r; din_valid = v; sync = s; err_clr = clr; din = d;
        e.dv = '0;
        e.fd = 1'b0;
        if (r) begin
            m_locked = 0; m_slot = 0; m_err = 0;
            for (int k = 0; k < C; k++) m_ch[k] = '0;
        end else begin
            if (clr) m_err = 0;
            if (v) begin
                if (s) begin
                    if (m_locked && m_slot != 0) m_err = 1;
                    m_ch[0] = d;
                    e.dv = 1;
                    m_slot = 1;
                    m_locked = 1;
                end else if (m_locked) begin
                    if (m_slot == 0) begin
                        m_err = 1;
                        m_locked = 0;
                    end else begin
                        m_ch[m_slot] = d;
                        e.dv = C'(1 << m_slot);
                        e.fd = (m_slot == C - 1);
                        m_slot = (m_slot + 1) % C;
                    end
                end
            end
        end
        for (int k = 0; k < C; k++) e.dout[k*W +: W] = m_ch[k];
        e.lk = m_locked;
        e.sl = SW'(m_slot);
        e.er = m_err;
        q.push_back(e);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 8'h00);
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("dout",       64'(dout),       64'(e.dout));
                chk("dout_valid", 64'(dout_valid), 64'(e.dv));
                chk("frame_done", 64'(frame_done), 64'(e.fd));
                chk("locked",     64'(locked),     64'(e.lk));
                chk("slot",       64'(slot),       64'(e.sl));
                chk("sync_err",   64'(sync_err),   64'(e.er));
            end
        end
    end

    initial begin
        bit s;
        drive(1, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 8'h00);
        // Clean frame
        drive(0, 1, 1, 0, 8'h11);
        drive(0, 1, 0, 0, 8'h22);
        drive(0, 1, 0, 0, 8'h33);
        drive(0, 1, 0, 0, 8'h44);
        // Missing sync at slot 0, then samples in HUNT are dropped, then relock
        drive(0, 1, 0, 0, 8'h77);
        drive(0, 1, 0, 0, 8'hAA);
        drive(0, 1, 0, 0, 8'hBB);
        drive(0, 1, 1, 0, 8'h11);
        drive(0, 1, 0, 0, 8'h22);
        // Early sync at slot 2 together with err_clr: set wins
        drive(0, 1, 1, 1, 8'h55);
        drive(0, 0, 0, 1, 8'h00);
        // Frame with gaps
        drive(0, 1, 0, 0, 8'h66);
        gap(2);
        drive(0, 1, 0, 0, 8'h67);
        gap(1);
        drive(0, 1, 0, 0, 8'h68);
        gap(3);
        drive(0, 1, 1, 0, 8'h01);
        drive(0, 1, 0, 0, 8'h02);
        // Reset mid-frame at slot 2
        drive(1, 1, 0, 0, 8'h03);
        drive(0, 1, 0, 0, 8'h04);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (m_slot == 0) s = ($urandom % 8) != 0;
            else             s = ($urandom % 10) == 0;
            drive(($urandom % 64) == 0, ($urandom % 4) != 0, s,
                  ($urandom % 16) == 0, W'($urandom));
        end
        drive(0, 0, 0, 0, 8'h00);
        repeat (4) @(posedge clk);
        #2;
        chk("drain", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
